// File: rtl/avalmm_pkg.sv
// Shared definitions for the Avalon-MM control-register host:
// FSM state encoding, register map addresses and measurement field widths.
package avalmm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2,
        RESP    = 2'd3
    } state_e;

    localparam logic [4:0] ADDR_FREQ   = 5'd0;
    localparam logic [4:0] ADDR_AMPL   = 5'd1;
    localparam logic [4:0] ADDR_DECI   = 5'd2;
    localparam logic [4:0] ADDR_TRIG   = 5'd3;
    localparam logic [4:0] ADDR_EDGE   = 5'd4;
    localparam logic [4:0] ADDR_RUN    = 5'd5;
    localparam logic [4:0] ADDR_HSHIFT = 5'd6;
    localparam logic [4:0] ADDR_VSHIFT = 5'd7;
    localparam logic [4:0] ADDR_VSCALE = 5'd8;

    localparam int unsigned FREQ_W = 20;
    localparam int unsigned AMPL_W = 8;

endpackage

// File: rtl/avalmm_host.sv
// Avalon-MM host: turns a valid/ready command stream into single Avalon
// read/write transfers with waitrequest, fixed read latency and a stall
// timeout, returning one response per command.
// Optional macro AVALMM_HOST_POLL_EN adds a periodic internal burst that
// reads the frequency and amplitude registers into meas_* outputs.
module avalmm_host
    import avalmm_pkg::*;
#(
    parameter int unsigned RD_LATENCY  = 1,
    parameter int unsigned TIMEOUT     = 255,
    parameter int unsigned POLL_PERIOD = 50_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [4:0]        cmd_addr,
    input  logic [31:0]       cmd_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_timeout,
    output logic              avalon_write,
    output logic              avalon_read,
    output logic [4:0]        avalon_address,
    output logic [31:0]       avalon_writedata,
    input  logic [31:0]       avalon_readdata,
    input  logic              avalon_waitrequest,
    output logic [FREQ_W-1:0] meas_freq,
    output logic [AMPL_W-1:0] meas_vpp,
    output logic [AMPL_W-1:0] meas_max,
    output logic [AMPL_W-1:0] meas_min
);

    state_e      state_q, state_d;
    logic        wr_q, wr_d;
    logic [4:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  lat_cnt_q, lat_cnt_d;
    logic [15:0] to_cnt_q, to_cnt_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        write_q, write_d;
    logic        read_q, read_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_timeout_q, rsp_timeout_d;
    logic        capture;
    logic        poll_now;

`ifdef AVALMM_HOST_POLL_EN
    logic [31:0]       poll_cnt_q, poll_cnt_d;
    logic              poll_pending_q, poll_pending_d;
    logic              is_poll_q, is_poll_d;
    logic              poll_idx_q, poll_idx_d;
    logic [FREQ_W-1:0] meas_freq_q, meas_freq_d;
    logic [AMPL_W-1:0] meas_vpp_q, meas_vpp_d;
    logic [AMPL_W-1:0] meas_max_q, meas_max_d;
    logic [AMPL_W-1:0] meas_min_q, meas_min_d;
`endif

    // Next-state and next-output logic for the transfer FSM (and poll burst)
    always_comb begin
        state_d       = state_q;
        wr_d          = wr_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        lat_cnt_d     = lat_cnt_q;
        to_cnt_d      = to_cnt_q;
        cmd_ready_d   = cmd_ready_q;
        write_d       = write_q;
        read_d        = read_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_timeout_d = 1'b0;
        capture       = 1'b0;
`ifdef AVALMM_HOST_POLL_EN
        poll_cnt_d     = poll_cnt_q;
        poll_pending_d = poll_pending_q;
        is_poll_d      = is_poll_q;
        poll_idx_d     = poll_idx_q;
        meas_freq_d    = meas_freq_q;
        meas_vpp_d     = meas_vpp_q;
        meas_max_d     = meas_max_q;
        meas_min_d     = meas_min_q;
        poll_now       = is_poll_q;
`else
        poll_now       = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    wr_d        = cmd_write;
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    write_d     = cmd_write;
                    read_d      = ~cmd_write;
                    to_cnt_d    = '0;
                    rsp_rdata_d = '0;
                    cmd_ready_d = 1'b0;
                    state_d     = ISSUE;
`ifdef AVALMM_HOST_POLL_EN
                    is_poll_d   = 1'b0;
                end else if (poll_pending_q && cmd_ready_q) begin
                    // External commands take priority; poll starts only when none is offered
                    wr_d           = 1'b0;
                    addr_d         = ADDR_FREQ;
                    read_d         = 1'b1;
                    to_cnt_d       = '0;
                    cmd_ready_d    = 1'b0;
                    is_poll_d      = 1'b1;
                    poll_idx_d     = 1'b0;
                    poll_pending_d = 1'b0;
                    state_d        = ISSUE;
`endif
                end
            end

            ISSUE: begin
                if (avalon_waitrequest) begin
                    if (to_cnt_q == 16'(TIMEOUT)) begin
                        write_d       = 1'b0;
                        read_d        = 1'b0;
                        rsp_rdata_d   = '0;
                        rsp_valid_d   = ~poll_now;
                        rsp_timeout_d = ~poll_now;
                        state_d       = RESP;
                    end else begin
                        to_cnt_d = to_cnt_q + 16'd1;
                    end
                end else begin
                    write_d = 1'b0;
                    read_d  = 1'b0;
                    if (wr_q) begin
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end else if (RD_LATENCY == 0) begin
                        capture     = 1'b1;
                        rsp_valid_d = ~poll_now;
                        state_d     = RESP;
                    end else begin
                        lat_cnt_d = 2'd1;
                        state_d   = RD_WAIT;
                    end
                end
            end

            RD_WAIT: begin
                if (lat_cnt_q == 2'(RD_LATENCY)) begin
                    capture     = 1'b1;
                    rsp_valid_d = ~poll_now;
                    state_d     = RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end

            RESP: begin
                cmd_ready_d = 1'b1;
                state_d     = IDLE;
`ifdef AVALMM_HOST_POLL_EN
                // First poll read done: chain straight into the amplitude read
                if (is_poll_q && !poll_idx_q) begin
                    addr_d      = ADDR_AMPL;
                    read_d      = 1'b1;
                    to_cnt_d    = '0;
                    poll_idx_d  = 1'b1;
                    cmd_ready_d = 1'b0;
                    state_d     = ISSUE;
                end else begin
                    is_poll_d = 1'b0;
                end
`endif
            end

            default: state_d = IDLE;
        endcase

`ifdef AVALMM_HOST_POLL_EN
        if (capture && poll_now) begin
            if (!poll_idx_q) begin
                meas_freq_d = avalon_readdata[FREQ_W-1:0];
            end else begin
                {meas_vpp_d, meas_max_d, meas_min_d} = avalon_readdata[3*AMPL_W-1:0];
            end
        end else if (capture) begin
            rsp_rdata_d = avalon_readdata;
        end

        // Free-running period counter; a tick during a burst just re-arms the flag
        if (poll_cnt_q == 32'(POLL_PERIOD - 1)) begin
            poll_cnt_d     = '0;
            poll_pending_d = 1'b1;
        end else begin
            poll_cnt_d = poll_cnt_q + 32'd1;
        end
`else
        if (capture) begin
            rsp_rdata_d = avalon_readdata;
        end
`endif
    end

    // State and registered outputs, all cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wr_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            lat_cnt_q     <= '0;
            to_cnt_q      <= '0;
            cmd_ready_q   <= 1'b0;
            write_q       <= 1'b0;
            read_q        <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
`ifdef AVALMM_HOST_POLL_EN
            poll_cnt_q     <= '0;
            poll_pending_q <= 1'b0;
            is_poll_q      <= 1'b0;
            poll_idx_q     <= 1'b0;
            meas_freq_q    <= '0;
            meas_vpp_q     <= '0;
            meas_max_q     <= '0;
            meas_min_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            wr_q          <= wr_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            lat_cnt_q     <= lat_cnt_d;
            to_cnt_q      <= to_cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            write_q       <= write_d;
            read_q        <= read_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
`ifdef AVALMM_HOST_POLL_EN
            poll_cnt_q     <= poll_cnt_d;
            poll_pending_q <= poll_pending_d;
            is_poll_q      <= is_poll_d;
            poll_idx_q     <= poll_idx_d;
            meas_freq_q    <= meas_freq_d;
            meas_vpp_q     <= meas_vpp_d;
            meas_max_q     <= meas_max_d;
            meas_min_q     <= meas_min_d;
`endif
        end
    end

    assign cmd_ready        = cmd_ready_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_rdata        = rsp_rdata_q;
    assign rsp_timeout      = rsp_timeout_q;
    assign avalon_write     = write_q;
    assign avalon_read      = read_q;
    assign avalon_address   = addr_q;
    assign avalon_writedata = wdata_q;

`ifdef AVALMM_HOST_POLL_EN
    assign meas_freq = meas_freq_q;
    assign meas_vpp  = meas_vpp_q;
    assign meas_max  = meas_max_q;
    assign meas_min  = meas_min_q;
`else
    assign meas_freq = '0;
    assign meas_vpp  = '0;
    assign meas_max  = '0;
    assign meas_min  = '0;
`endif

endmodule

// File: doc/avalmm_host.md
Name: avalmm_host

Overview:
- Avalon-MM host (master) for the scope's control-register space; it is the initiator for the register slave that holds decimation, trigger, shift and scale settings and returns frequency, Vpp, max and min.
- Converts a simple valid/ready command stream (from UART or key-menu logic) into single Avalon read/write transfers.
- Supports waitrequest, a fixed read latency and a transfer timeout.
- Returns one response per command.

Parameters:
- RD_LATENCY, 1, cycles from read acceptance to readdata valid (legal 0..3).
- TIMEOUT, 255, max consecutive waitrequest cycles before abort (1..65535).
- POLL_PERIOD, 50_000_000, clk cycles between auto-poll bursts (only with AVALMM_HOST_POLL_EN).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  host can accept a command
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  5  register address
- cmd_wdata  in  32  write data
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  32  read data (0 for writes or timeout)
- rsp_timeout  out  1  transfer aborted, qualified by rsp_valid
- avalon_write  out  1  write strobe
- avalon_read  out  1  read strobe
- avalon_address  out  5  address
- avalon_writedata  out  32  write data
- avalon_readdata  in  32  read data
- avalon_waitrequest  in  1  slave stall (tie 0 for zero-wait slaves)
- meas_freq  out  20  polled frequency
- meas_vpp, meas_max, meas_min  out  8 each  polled amplitude fields

Behaviour:
- One clock. Reset is asynchronous and active-low. Ports are named clk and rst_n.
- Reset values: all outputs 0; FSM in IDLE; counters 0.
- States: IDLE, ISSUE, RD_WAIT, RESP.
- IDLE
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch write/addr/wdata and go to ISSUE.
- ISSUE
  - Drive avalon_read or avalon_write, plus avalon_address and avalon_writedata, from registered values.
  - Strobe, address and data are held stable while avalon_waitrequest=1.
  - The transfer is accepted in the first ISSUE cycle with waitrequest=0.
  - Strobes drop the cycle after acceptance.
- Write path: after acceptance go to RESP.
- Read path
  - RD_LATENCY=0: sample avalon_readdata in the acceptance cycle, then go to RESP.
  - RD_LATENCY=N>0: go to RD_WAIT, count N cycles, sample readdata in the Nth cycle after acceptance, then go to RESP.
- RESP: rsp_valid=1 for exactly one cycle with rsp_rdata and rsp_timeout, then IDLE. cmd_ready=0 outside IDLE.
- Latency with zero wait, command accepted in cycle T:
  - write: avalon_write high in T+1, rsp_valid in T+2;
  - read with RD_LATENCY=1: avalon_read in T+1, sample in T+2, rsp_valid in T+3.
- Timeout
  - A 16-bit counter increments each ISSUE cycle with waitrequest=1 and clears on entry to ISSUE.
  - When it reaches TIMEOUT while still stalled, strobes drop next cycle and the FSM goes to RESP with rsp_timeout=1 and rsp_rdata=0.
- Reset mid-transfer: strobes, rsp_valid and cmd_ready go to 0 immediately (async); the transfer is lost, no response.
- cmd inputs are ignored outside IDLE; there is no queuing.

Optional Feature:
- Macro AVALMM_HOST_POLL_EN.
- With the macro:
  - A free-running counter raises poll_pending every POLL_PERIOD cycles.
  - In IDLE with poll_pending=1 and cmd_valid=0, the host internally issues read addr 0, then read addr 1, using the same ISSUE/RD_WAIT path.
  - cmd_ready=0 during the burst. External commands win ties.
  - Results load meas_freq=rdata[19:0] (addr 0) and {meas_vpp,meas_max,meas_min}=rdata[23:0] (addr 1).
  - Poll reads never assert rsp_valid.
  - A poll timeout leaves the meas_* registers unchanged.
  - A poll request arriving during a burst is merged into the pending flag.
- Without the macro: no poll logic; meas_* are tied 0.

Decomposition:
- Shared package avalmm_pkg holds:
  - the state encoding typedef;
  - address constants ADDR_FREQ=0, ADDR_AMPL=1, ADDR_DECI=2, ADDR_TRIG=3, ADDR_EDGE=4, ADDR_RUN=5, ADDR_HSHIFT=6, ADDR_VSHIFT=7, ADDR_VSCALE=8;
  - field width constants (freq 20, amplitude 8).
- No sub-module is required. The poll timer may be a small avalmm_poll_timer instance under the macro.

Test Plan:
- Write addr 2 data 4, zero wait -> avalon_write=1 in T+1 only, address=2, writedata=4; rsp_valid in T+2 with rdata=0, timeout=0.
- Read addr 0, slave model returning 0x00012345 one cycle after read, RD_LATENCY=1 -> avalon_read one cycle; rsp_rdata=0x00012345 in T+3.
- Write addr 3 data 0x9480 with waitrequest high 3 cycles -> strobe, address and data stable 4 cycles; rsp_valid in T+5.
- TIMEOUT=8, waitrequest stuck high on a read -> strobe high 9 cycles then low; rsp_valid=1, rsp_timeout=1, rsp_rdata=0; cmd_ready returns next cycle.
- rst_n pulled low in the ISSUE cycle of a read -> avalon_read=0 asynchronously; no rsp_valid after release; cmd_ready=1 on first clock after release.
- With AVALMM_HOST_POLL_EN and POLL_PERIOD=100, slave freq=1000, amplitude word 0x00C8E020 -> reads addr 0 then 1 every 100 cycles; meas_freq=1000, meas_vpp=0xC8, meas_max=0xE0, meas_min=0x20; rsp_valid stays 0.
